// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter giving NUM_REQ byte sources turns on one shared UART transmitter.
// Latency : a byte accepted in cycle N gives tx_start in cycle N+1; the next accept comes no earlier than the cycle after tx_done.
// Backpress: req_ready is offered only in IDLE, one-hot to the winner; requesters hold req_valid until they see req_ready.
//
// Ports:
//   clk, rst                 - single clock; synchronous active-high reset
//   req_valid/req_data       - per-requester byte offer; byte i is at [DATA_W*i +: DATA_W]
//   req_ready                - combinational one-hot accept, high in IDLE only
//   tx_start/tx_data/tx_done - handshake with the shared transmitter
//   grant_id, busy           - current owner and "not IDLE" status
//   timeout_err              - sticky watchdog flag
//
// Build option: define UART_ARB_TIMEOUT_EN to enable the WAIT watchdog.
// Without it, WAIT exits only on tx_done and timeout_err is tied low.
module uart_tx_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = 8,
    parameter  int TIMEOUT_CYCLES = 65536,
    localparam int GID_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // Winner search: the first valid bit at or after rr_ptr, wrapping at NUM_REQ-1.
    // Walk the offsets from the highest down so that the smallest offset is written last and wins.
    logic                any_vld;
    logic [GID_W-1:0]    win_idx;
    int                  scan_idx;

    always_comb begin
        any_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req_valid[scan_idx]) begin
                any_vld = 1'b1;
                win_idx = GID_W'(scan_idx);
            end
        end
    end

    // Pointer that follows the current owner; used both on tx_done and on watchdog expiry.
    logic [GID_W-1:0]    next_ptr;
    assign next_ptr = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GID_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        req_ready  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                // No accept is offered during reset, so no requester can
                // believe it handed off a byte that reset then discards.
                if (any_vld && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    tx_data_d          = req_data[DATA_W*win_idx +: DATA_W];
                    grant_id_d         = win_idx;
                    tx_start_d         = 1'b1;
                    state_d            = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                // tx_done has priority over the watchdog expiring in the same cycle.
                if (tx_done) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65536;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: phase 0 = no owner, 1 = start pulse due, 2 = owner waiting for tx_done.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_gid   = 0;
    int          m_wcnt  = 0;
    logic [7:0]  m_data  = 8'h00;
    logic        m_err   = 1'b0;
    int          glog[$];

    logic [3:0]  obs_ready;
    logic        obs_start, obs_busy, obs_err;
    logic [7:0]  obs_data;
    logic [1:0]  obs_gid;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic done, input logic r);
        logic [3:0] exp_ready;
        int         w;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        tx_done   = done;
        rst       = r;
        #1;
        exp_ready = 4'b0000;
        if (!r && m_phase == 0 && v != 4'b0000) exp_ready[pick(v, m_ptr)] = 1'b1;
        obs_ready = req_ready;
        obs_start = tx_start;
        obs_data  = tx_data;
        obs_gid   = grant_id;
        obs_busy  = busy;
        obs_err   = timeout_err;
        chk("req_ready", {28'd0, obs_ready}, {28'd0, exp_ready});
        chk("tx_start", {31'd0, obs_start}, {31'd0, m_phase == 1});
        chk("tx_data", {24'd0, obs_data}, {24'd0, m_data});
        chk("grant_id", {30'd0, obs_gid}, m_gid);
        chk("busy", {31'd0, obs_busy}, {31'd0, m_phase != 0});
        chk("timeout_err", {31'd0, obs_err}, {31'd0, m_err});
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_ptr = 0; m_gid = 0; m_data = 8'h00; m_err = 1'b0;
        end else begin
            case (m_phase)
                0: if (v != 4'b0000) begin
                    w = pick(v, m_ptr);
                    m_gid = w;
                    m_data = d[8*w +: 8];
                    glog.push_back(w);
                    m_phase = 1;
                end
                1: begin
                    m_phase = 2;
                    m_wcnt = 0;
                end
                default: begin
                    if (done) begin
                        m_ptr = (m_gid + 1) % NR;
                        m_phase = 0;
                    end else begin
                        m_wcnt++;
`ifdef UART_ARB_TIMEOUT_EN
                        if (m_wcnt == TO) begin
                            m_err = 1'b1;
                            m_ptr = (m_gid + 1) % NR;
                            m_phase = 0;
                        end
`endif
                    end
                end
            endcase
        end
    endtask

    // n frames from an idle arbiter, tx_done arriving 'delay' cycles after each tx_start.
    task automatic run_frames(input logic [3:0] v, input logic [31:0] d, input int delay, input int n);
        for (int f = 0; f < n; f++) begin
            cycle(v, d, 1'b0, 1'b0);
            cycle(v, d, 1'b0, 1'b0);
            repeat (delay - 1) cycle(v, d, 1'b0, 1'b0);
            cycle(v, d, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  v;
        logic        done;
        logic        r;
        int          lat;

        rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state with an active request offered during reset.
        cycle(4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("rst_ready", {28'd0, obs_ready}, 32'd0);
        cycle(4'b0000, 32'd0, 1'b0, 1'b0);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("rst_data", {24'd0, obs_data}, 32'd0);

        // Single requester 2, byte A5.
        d = {8'h11, 8'hA5, 8'h22, 8'h33};
        cycle(4'b0100, d, 1'b0, 1'b0);
        chk("r034_ready", {28'd0, obs_ready}, 32'h4);
        chk("r034_nostart", {31'd0, obs_start}, 32'd0);
        cycle(4'b0100, d, 1'b0, 1'b0);
        chk("r034_start", {31'd0, obs_start}, 32'd1);
        chk("r034_data", {24'd0, obs_data}, 32'hA5);
        chk("r034_gid", {30'd0, obs_gid}, 32'd2);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b1, 1'b0);

        // Pointer now at 3: requesters 3 and 0 wrap.
        glog.delete();
        run_frames(4'b1001, $urandom, 4, 2);
        chk("r036_n", glog.size(), 32'd2);
        if (glog.size() == 2) begin
            chk("r036_g0", glog[0], 32'd3);
            chk("r036_g1", glog[1], 32'd0);
        end

        // All requesters active: strict rotation 0,1,2,3,0.
        cycle(4'b0000, 32'd0, 1'b0, 1'b1);
        glog.delete();
        run_frames(4'b1111, $urandom, 10, 5);
        chk("r035_n", glog.size(), 32'd5);
        for (int i = 0; i < glog.size(); i++) chk("r035_rot", glog[i], i % NR);

        // Reset while waiting, then a stale tx_done.
        d = $urandom;
        cycle(4'b0010, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        chk("r037_busy_pre", {31'd0, obs_busy}, 32'd1);
        cycle(4'b0000, d, 1'b0, 1'b1);
        cycle(4'b0000, d, 1'b0, 1'b0);
        chk("r037_busy", {31'd0, obs_busy}, 32'd0);
        chk("r037_gid", {30'd0, obs_gid}, 32'd0);
        chk("r037_data", {24'd0, obs_data}, 32'd0);
        cycle(4'b0000, d, 1'b1, 1'b0);
        cycle(4'b0011, d, 1'b0, 1'b0);
        chk("r037_stale", {31'd0, obs_busy}, 32'd0);
        chk("r037_ptr", {28'd0, obs_ready}, 32'h1);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b1, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog expiry after TO waiting cycles, then the next requester.
        cycle(4'b0000, 32'd0, 1'b0, 1'b1);
        d = $urandom;
        cycle(4'b0110, d, 1'b0, 1'b0);
        cycle(4'b0110, d, 1'b0, 1'b0);
        repeat (TO - 1) cycle(4'b0110, d, 1'b0, 1'b0);
        chk("r038_err_pre", {31'd0, obs_err}, 32'd0);
        cycle(4'b0110, d, 1'b0, 1'b0);
        chk("r038_busy_last", {31'd0, obs_busy}, 32'd1);
        cycle(4'b0110, d, 1'b0, 1'b0);
        chk("r038_err", {31'd0, obs_err}, 32'd1);
        chk("r038_next", {28'd0, obs_ready}, 32'h4);
        cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b1, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        chk("r038_sticky", {31'd0, obs_err}, 32'd1);

        // tx_done on the expiry cycle wins.
        cycle(4'b0000, 32'd0, 1'b0, 1'b1);
        cycle(4'b0001, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        repeat (TO - 1) cycle(4'b0000, d, 1'b0, 1'b0);
        cycle(4'b0000, d, 1'b1, 1'b0);
        cycle(4'b0000, d, 1'b0, 1'b0);
        chk("r039_err", {31'd0, obs_err}, 32'd0);
        chk("r039_busy", {31'd0, obs_busy}, 32'd0);
`endif

        // Randomized traffic with spurious tx_done and occasional resets.
        cycle(4'b0000, 32'd0, 1'b0, 1'b1);
        lat = 0;
        repeat (3000) begin
            v = 4'($urandom_range(0, 15));
            d = $urandom;
            r = ($urandom_range(0, 99) == 0);
            done = 1'b0;
            if (m_phase == 1) begin
                lat = $urandom_range(1, 12);
                done = ($urandom_range(0, 5) == 0);
            end else if (m_phase == 2) begin
                lat--;
                done = (lat <= 0);
            end else begin
                done = ($urandom_range(0, 5) == 0);
            end
            cycle(v, d, done, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
